// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the console UART blocks: bit-time reload constants,
// receiver FSM encoding and register bit positions.
package fifo_uart_pkg;

    // Divider reload for one full bit time: round(clk_rate / bit_rate) - 1.
    function automatic int unsigned fullbit_reload(input int unsigned clk_rate,
                                                   input int unsigned bit_rate);
        return (clk_rate + bit_rate / 2) / bit_rate - 1;
    endfunction

    // Divider reload for half a bit time: round(clk_rate / (2 * bit_rate)) - 1.
    function automatic int unsigned halfbit_reload(input int unsigned clk_rate,
                                                   input int unsigned bit_rate);
        return (clk_rate + bit_rate) / (2 * bit_rate) - 1;
    endfunction

    typedef enum logic [2:0] {
        StArm,
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

    // Status register layout
    localparam int unsigned StatValidBit = 8;
    localparam int unsigned StatFeBit    = 9;
    localparam int unsigned StatOvBit    = 10;
    localparam int unsigned StatBrkBit   = 11;
    localparam int unsigned StatFillLsb  = 16;
    localparam int unsigned StatFillW    = 13;

    // Control register layout
    localparam int unsigned CtrlPopBit = 8;
    localparam int unsigned CtrlClrBit = 9;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: dual-port RAM with head/tail pointers and a prefetch register
// that always presents the oldest entry. The entry stays in the RAM until it
// is popped, so capacity is 2^L2_FIFO_SIZE-1 bytes including the shown one.
module uart_rx_fifo #(
    parameter int unsigned L2_FIFO_SIZE = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        pop,
    output logic [7:0]  head_byte,
    output logic        head_valid,
    output logic [12:0] fill,
    output logic        drop
);

    localparam int unsigned Depth = 1 << L2_FIFO_SIZE;
    localparam int unsigned AW    = L2_FIFO_SIZE;

    logic [7:0]    mem [Depth];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW-1:0] used;
    logic [7:0]    dout_q;
    logic          valid_q;
    logic          full;
    logic          empty;
    logic          do_write;
    logic          do_pop;
    logic          load;

    // Full/empty come from registered pointers only, so a same-cycle pop
    // cannot make room for a write.
    assign full     = (head_q + AW'(1)) == tail_q;
    assign empty    = head_q == tail_q;
    assign do_write = wr_en && !full;
    assign drop     = wr_en && full;
    assign do_pop   = pop && valid_q;
    assign load     = !valid_q && !empty;
    assign used     = head_q - tail_q;

    // RAM write port
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[head_q] <= wr_data;
        end
    end

    // RAM read port feeding the prefetch register
    always_ff @(posedge clk) begin
        if (load) begin
            dout_q <= mem[tail_q];
        end
    end

    // Pointers and prefetch-valid; a pop blanks the head for one cycle before
    // the next entry is fetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (do_write) begin
                head_q <= head_q + AW'(1);
            end
            if (do_pop) begin
                tail_q  <= tail_q + AW'(1);
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign head_byte  = valid_q ? dout_q : 8'h00;
    assign head_valid = valid_q;
    assign fill       = {{(13 - AW){1'b0}}, used};

endmodule

// File: rtl/fifo_uart_rx.sv
// Console UART receiver: synchronizer, majority-sampled 8N1 receive FSM,
// sticky line-error flags and a deep receive FIFO behind the status register.
module fifo_uart_rx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned CLK_RATE     = 100000000,
    parameter int unsigned BIT_RATE     = 115200,
    parameter int unsigned L2_FIFO_SIZE = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RxData,
    input  logic        strobe,
    input  logic [31:0] control,
    output logic [31:0] status
);

    localparam int unsigned FullReload = fullbit_reload(CLK_RATE, BIT_RATE);
    localparam int unsigned HalfReload = halfbit_reload(CLK_RATE, BIT_RATE);
    localparam int unsigned DivW       = $clog2(FullReload + 1);
    localparam logic [DivW-1:0] FullDiv = DivW'(FullReload);
    localparam logic [DivW-1:0] HalfDiv = DivW'(HalfReload);

    logic            s1_q, s2_q, s3_q;
    rx_state_e       state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            wr_q, wr_d;
    logic            fe_q, ov_q, brk_q;
    logic            fe_set, brk_set;
    logic            div_zero;
    logic            maj;
    logic            pop_req, clr_req;
    logic [7:0]      head_byte;
    logic            head_valid;
    logic [12:0]     fill;
    logic            drop;
    logic            unused_control;

    assign pop_req        = strobe & control[CtrlPopBit];
    assign clr_req        = strobe & control[CtrlClrBit];
    assign unused_control = ^{control[31:10], control[7:0]};

    // s3/s2/s1 hold s2 as seen at divider values 1, 0 and reload.
    assign maj      = (s3_q & s2_q) | (s3_q & s1_q) | (s2_q & s1_q);
    assign div_zero = (div_q == '0);

    // Synchronizer and edge-detect delay; idle-high reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= RxData;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Receive FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StArm;
            div_q    <= FullDiv;
            bitcnt_q <= '0;
            shift_q  <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            wr_q     <= wr_d;
        end
    end

    // Receive FSM next state, bit timing and frame decisions
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        wr_d     = 1'b0;
        fe_set   = 1'b0;
        brk_set  = 1'b0;
        unique case (state_q)
            StArm: begin
                // Leave only when the next sample is high too: a single high
                // data bit inside a frame lasts exactly one bit time and must
                // not be mistaken for idle line.
                if (!s2_q) begin
                    div_d = FullDiv;
                end else if (!div_zero) begin
                    div_d = div_q - DivW'(1);
                end else if (s1_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (s3_q && !s2_q) begin
                    div_d   = HalfDiv;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (!div_zero) begin
                    div_d = div_q - DivW'(1);
                end else if (maj) begin
                    state_d = StIdle;
                end else begin
                    div_d    = FullDiv;
                    bitcnt_d = 4'd8;
                    state_d  = StData;
                end
            end
            StData: begin
                if (!div_zero) begin
                    div_d = div_q - DivW'(1);
                end else begin
                    shift_d  = {maj, shift_q[7:1]};
                    bitcnt_d = bitcnt_q - 4'd1;
                    div_d    = FullDiv;
                    if (bitcnt_q == 4'd1) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (!div_zero) begin
                    div_d = div_q - DivW'(1);
                end else if (maj) begin
                    wr_d    = 1'b1;
                    state_d = StIdle;
                end else begin
                    fe_set  = 1'b1;
                    brk_set = (shift_q == 8'h00);
                    div_d   = FullDiv;
                    state_d = StArm;
                end
            end
            default: begin
                div_d   = FullDiv;
                state_d = StArm;
            end
        endcase
    end

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_q  <= 1'b0;
            ov_q  <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            fe_q  <= fe_set  | (fe_q  & ~clr_req);
            ov_q  <= drop    | (ov_q  & ~clr_req);
            brk_q <= brk_set | (brk_q & ~clr_req);
        end
    end

    uart_rx_fifo #(
        .L2_FIFO_SIZE (L2_FIFO_SIZE)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_q),
        .wr_data    (shift_q),
        .pop        (pop_req),
        .head_byte  (head_byte),
        .head_valid (head_valid),
        .fill       (fill),
        .drop       (drop)
    );

    // Status register assembly
    always_comb begin
        status                               = '0;
        status[7:0]                          = head_byte;
        status[StatValidBit]                 = head_valid;
        status[StatFeBit]                    = fe_q;
        status[StatOvBit]                    = ov_q;
        status[StatBrkBit]                   = brk_q;
        status[StatFillLsb +: StatFillW]     = fill;
    end

endmodule

// File: tb/tb_fifo_uart_rx.sv
// Bench for fifo_uart_rx: two instances (deep and 15-entry FIFO) share one
// serial line. A queue-based model of each status register is compared every
// cycle while no transaction is settling; literal checks pin exact timing.
module tb_fifo_uart_rx;

    localparam int unsigned ClkRate = 100_000_000;
    localparam int unsigned BitRate = 6_250_000;  // 16 clocks per bit
    localparam int unsigned BitClks = 16;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        rx_line  = 1'b1;
    logic        strobe_a = 1'b0;
    logic        strobe_b = 1'b0;
    logic [31:0] control  = '0;
    logic [31:0] status_a;
    logic [31:0] status_b;

    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en   = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         fe[2];
    bit         ov[2];
    bit         brk[2];
    int         cap[2] = '{511, 15};

    fifo_uart_rx #(
        .CLK_RATE     (ClkRate),
        .BIT_RATE     (BitRate),
        .L2_FIFO_SIZE (9)
    ) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .RxData  (rx_line),
        .strobe  (strobe_a),
        .control (control),
        .status  (status_a)
    );

    fifo_uart_rx #(
        .CLK_RATE     (ClkRate),
        .BIT_RATE     (BitRate),
        .L2_FIFO_SIZE (4)
    ) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .RxData  (rx_line),
        .strobe  (strobe_b),
        .control (control),
        .status  (status_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected status from the model: head byte (0 when empty), valid, flags, fill.
    function automatic logic [31:0] model_status(input int i);
        int         n;
        logic [7:0] hd;
        if (i == 0) begin
            n  = q0.size();
            hd = (n > 0) ? q0[0] : 8'h00;
        end else begin
            n  = q1.size();
            hd = (n > 0) ? q1[0] : 8'h00;
        end
        return (32'(n) << 16) | (32'(brk[i]) << 11) | (32'(ov[i]) << 10) |
               (32'(fe[i]) << 9) | ((n > 0) ? 32'h100 : 32'h0) | 32'(hd);
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            fe[i] = 0; ov[i] = 0; brk[i] = 0;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        for (int i = 0; i < 2; i++) begin
            if (stop_ok) begin
                if (i == 0) begin
                    if (q0.size() == cap[0]) ov[0] = 1; else q0.push_back(b);
                end else begin
                    if (q1.size() == cap[1]) ov[1] = 1; else q1.push_back(b);
                end
            end else begin
                fe[i] = 1;
                if (b == 8'h00) brk[i] = 1;
            end
        end
    endtask

    task automatic model_pop(input logic [1:0] mask);
        if (mask[0] && q0.size() > 0) void'(q0.pop_front());
        if (mask[1] && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            fe[i] = 0; ov[i] = 0; brk[i] = 0;
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("status_a_model", status_a, model_status(0));
            check("status_b_model", status_b, model_status(1));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx_line = v;
        wait_cyc(BitClks);
    endtask

    // Starts immediately; caller is positioned 1 time unit after a posedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        chk_en = 0;
        drive_bit(stop_bit);
        rx_line = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input logic stop_bit, input bit apply);
        send_frame(b, stop_bit);
        wait_cyc(4);
        if (apply) model_frame(b, stop_bit);
        chk_en = 1;
    endtask

    // One-cycle register strobe at cycle P; returns during P+1.
    task automatic do_ctrl(input logic [1:0] mask, input logic [31:0] ctrl);
        chk_en   = 0;
        strobe_a = mask[0];
        strobe_b = mask[1];
        control  = ctrl;
        wait_cyc(1);
        strobe_a = 0;
        strobe_b = 0;
        control  = '0;
    endtask

    task automatic settle();
        wait_cyc(3);
        chk_en = 1;
    endtask

    initial begin
        int k;
        model_reset();
        #1 rst_n = 1'b0;
        wait_cyc(3);
        check("reset_status_a", status_a, 32'h0);
        check("reset_status_b", status_b, 32'h0);
        rst_n = 1'b1;
        chk_en = 1;
        wait_cyc(3 * BitClks);

        // 1: 0x55, exact visibility at S+3 (S = k+154), then pop timing
        k = cyc;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (cyc < k + 156) @(negedge clk);
                check("t1_s2_not_valid", 32'(status_a[8]), 32'h0);
                @(negedge clk);
                check("t1_s3_status_a", status_a, 32'h0001_0155);
                check("t1_s3_status_b", status_b, 32'h0001_0155);
            end
        join
        wait_cyc(4);
        model_frame(8'h55, 1'b1);
        chk_en = 1;
        wait_cyc(5);
        do_ctrl(2'b11, 32'h100);
        @(negedge clk);
        check("t1_pop_p1_valid", 32'(status_a[8]), 32'h0);
        @(negedge clk);
        check("t1_pop_p2_count", 32'(status_a[28:16]), 32'h0);
        model_pop(2'b11);
        settle();

        // 2: short low glitch is a false start, then 0x3C
        rx_line = 1'b0;
        wait_cyc(4);
        rx_line = 1'b1;
        wait_cyc(3 * BitClks);
        check("t2_glitch_no_byte", status_a, 32'h0);
        frame(8'h3C, 1'b1, 1);
        check("t2_byte_3c", status_a, 32'h0001_013C);
        do_ctrl(2'b11, 32'h100);
        model_pop(2'b11);
        settle();

        // 3: 0xA5 with low stop bit -> framing only; clear it
        frame(8'hA5, 1'b0, 1);
        check("t3_framing", status_a, 32'h0000_0200);
        wait_cyc(3 * BitClks);
        do_ctrl(2'b11, 32'h200);
        @(negedge clk);
        check("t3_clear_fe", 32'(status_a[9]), 32'h0);
        model_clear();
        settle();

        // 4: break, an early 0x41 during re-arm is ignored, a later one is kept
        chk_en  = 0;
        rx_line = 1'b0;
        wait_cyc(20 * BitClks);
        check("t4_break", status_a, 32'h0000_0A00);
        model_frame(8'h00, 1'b0);
        chk_en  = 1;
        rx_line = 1'b1;
        wait_cyc(5);
        frame(8'h41, 1'b1, 0);
        wait_cyc(3 * BitClks);
        check("t4_early_ignored", status_a, 32'h0000_0A00);
        frame(8'h41, 1'b1, 1);
        check("t4_byte_41", status_a, 32'h0001_0B41);
        do_ctrl(2'b11, 32'h300);
        @(negedge clk);
        check("t4_pop_clear", status_a, 32'h0);
        model_pop(2'b11);
        model_clear();
        settle();

        // 5: fill the 15-entry FIFO, overrun on the 16th byte, drain in order
        chk_en = 0;
        rst_n  = 1'b0;
        model_reset();
        wait_cyc(2);
        rst_n  = 1'b1;
        chk_en = 1;
        wait_cyc(2 * BitClks);
        for (int i = 0; i < 16; i++) begin
            frame(8'(i), 1'b1, 1);
            if (i == 14) check("t5_fill15", status_b, 32'h000F_0100);
        end
        check("t5_overrun", status_b, 32'h000F_0500);
        for (int i = 0; i < 15; i++) begin
            check("t5_pop_order", 32'(status_b[7:0]), 32'(i));
            do_ctrl(2'b10, 32'h100);
            model_pop(2'b10);
            settle();
        end
        check("t5_drained", status_b, 32'h0000_0400);

        // 6: reset during bit 4 with the line held low across release
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx_line = 1'b0;
        wait_cyc(8);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_reset_a", status_a, 32'h0);
        check("t6_reset_b", status_b, 32'h0);
        wait_cyc(10);
        rst_n = 1'b1;
        wait_cyc(5 * BitClks);
        check("t6_low_no_byte", status_a, 32'h0);
        rx_line = 1'b1;
        wait_cyc(3 * BitClks);
        frame(8'hC3, 1'b1, 1);
        check("t6_byte_c3", status_a, 32'h0001_01C3);
        wait_cyc(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_rx.md
Name: fifo_uart_rx

Overview:
Console UART receiver with a deep receive FIFO. It is the receive-side counterpart to the team's TX-FIFO console UART and removes that block's single-byte RX double-buffer limit. It sits on the same strobe/control/status register interface. Bytes are drained by software pops, and line errors are latched in sticky flags.

Parameters:
CLK_RATE, 100000000, clk frequency in Hz
BIT_RATE, 115200, serial bit rate in bit/s
L2_FIFO_SIZE, 9, log2 of RAM depth; usable capacity is 2^L2_FIFO_SIZE-1 bytes, range 4..12

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
RxData  in  1  serial line, asynchronous to clk, idle high
strobe  in  1  register write strobe, one cycle
control  in  32  write data: [8]=pop head byte, [9]=clear sticky flags, other bits ignored
status  out  32  [7:0]=head byte, [8]=rxValid, [9]=framingErr, [10]=overrun, [11]=breakSeen, [28:16]=fill count, others 0

Behaviour:
- Clocking/reset: one clock. Reset is asynchronous and active-low. Reset clears all state: pointers, flags, FSM (enters ARM), status=0.
- Constants: FULLBIT_RELOAD=round(CLK_RATE/BIT_RATE)-1. HALFBIT_RELOAD=round(CLK_RATE/(2*BIT_RATE))-1. Divider width=$clog2(FULLBIT_RELOAD+1).
- Input path: RxData passes through a 2-FF synchronizer (s1, s2), then a one-cycle delay s3 for edge detect. Each sample uses a 3-clock majority of s2 at divider values 1, 0 and reload.
- ARM: waits for the line high for FULLBIT_RELOAD+1 consecutive clocks, then goes to IDLE. Any low sample restarts the count. This guards against capturing mid-frame after reset or break.
- IDLE: falling edge (s3=1, s2=0) loads the divider with HALFBIT_RELOAD and goes to START.
- START: at divider 0, if the majority is high it is a false start; go to IDLE with no flag. Otherwise reload FULLBIT and go to DATA with bit count 8.
- DATA: at each divider 0, shift the majority sample in LSB-first and reload. After the 8th bit go to STOP.
- STOP, at divider 0 (cycle S):
  - Majority high: write the byte to the FIFO at S+1, or drop it and set overrun if the FIFO is full. Go to IDLE.
  - Majority low: set framingErr and queue nothing. If all data bits were 0, also set breakSeen. Go to ARM.
- FIFO: synchronous DPRAM with head/tail pointers of L2_FIFO_SIZE bits, modulo wrap. Full when head+1==tail; empty when head==tail. Full/empty are evaluated on registered pointers, so a pop in the same cycle as a write-to-full does not save the write.
- Prefetch output register: when the FIFO was empty, a byte whose stop sample is at S is visible as rxValid=1 with status[7:0] at S+3.
- Pop: strobe with control[8]=1 while rxValid=1.
  - rxValid is forced to 0 at P+1.
  - At P+2 the next entry is shown, or rxValid stays 0 if empty.
  - Pop while rxValid=0 is ignored.
- Fill count: entries held including the head register, 13 bits zero-extended.
- Clear: strobe with control[9]=1 clears framingErr, overrun and breakSeen at P+1. A flag-setting event in the same cycle wins, so the flag stays set.
- A single strobe may pop and clear together.
- Reset asserted mid-frame discards the partial byte. The post-reset ARM state prevents a false byte if the line is low at release.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - reload constant functions (shared with the TX UART);
  - FSM state encoding ARM/IDLE/START/DATA/STOP;
  - status and control bit-position localparams.
- One sub-module, uart_rx_fifo: DPRAM plus pointers, full/empty, prefetch register and fill count. The FSM stays in the top level.

Test Plan (CLK_RATE=100e6, BIT_RATE=115200, FULLBIT=867, HALFBIT=433):
1. After ARM, send 8N1 0x55 -> at S+3 status[8]=1, [7:0]=0x55, [28:16]=1. Pop -> status[8]=0 at P+1 and count 0 at P+2.
2. Low glitch of 200 clocks, then idle -> no byte, status=0. Then send 0x3C -> captured correctly.
3. Send 0xA5 with stop bit low -> framingErr=1, count 0, breakSeen=0. Strobe control=0x200 -> status[9]=0.
4. Hold line low 20 bit times, then high -> framingErr=1 and breakSeen=1, no byte. 0x41 sent within 500 clocks of the line going high is not captured; 0x41 sent after a full idle bit is captured.
5. L2_FIFO_SIZE=4: send 0x00..0x0F with no pops -> count 15, overrun=1 on the 16th. Popping 15 times yields 0x00..0x0E in order.
6. Assert rst_n=0 during bit 4 of a frame -> status=0 immediately. Line still low at release -> no byte until ARM completes; the next clean 0xC3 is received.
